bs_by2_acc_rx: RTL and testbench
================================

BS_BY2_ACC_RX -- requirements
Module: bs_by2_acc_rx

Interface
REQ-001 SHALL have parameter LANES, default 2: bitstream lanes delivered per beat; legal values 2, 4, 8, 16, 32.
REQ-002 SHALL have parameter COUNT_WIDTH, default 10: width of the binary ones-count result.
REQ-003 SHALL use one clock, clk; reset is synchronous and active-high, on port rst.
REQ-004 SHALL have ports, in this order:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- en  input  1  enables input acceptance
- bs_valid  input  1  beat present on bs_data
- bs_data  input  LANES  bitstream lanes for the beat
- bs_last  input  1  marks the final beat of the frame
- bs_ready  output  1  block accepts a beat this cycle
- out_ready  input  1  downstream accepts the result
- out_valid  output  1  countval holds a completed frame result
- countval  output  COUNT_WIDTH  ones-count (running or final)
- overflow  output  1  count saturated during the current or last frame
- busy  output  1  frame in progress (ACCUM state)

Function
REQ-005 SHALL implement a three-state FSM: IDLE, ACCUM, HOLD.
REQ-006 SHALL accept a beat only when bs_valid & bs_ready; bs_ready = en & (state != HOLD).
REQ-007 IDLE: on accepted beat, countval <= popcount(bs_data), overflow <= 0; next state is HOLD if bs_last, else ACCUM.
REQ-008 ACCUM: on each accepted beat, countval <= countval + popcount(bs_data); on a beat with bs_last, go to HOLD.
REQ-009 ACCUM with no accepted beat (bs_valid=0 or en=0): countval, overflow and state hold.
REQ-010 HOLD: out_valid=1, countval frozen; when out_ready=1, go to IDLE next cycle, and out_valid drops that cycle.
REQ-011 Latency: out_valid SHALL assert the cycle after the bs_last beat is accepted; countval then includes that beat.
REQ-012 HOLD with bs_valid=1 and out_ready=1 in the same cycle: the beat is not accepted (bs_ready=0); it is accepted no earlier than the following IDLE cycle.
REQ-013 Arithmetic: popcount is 0..LANES; the sum is computed at COUNT_WIDTH+1 bits.
REQ-014 If the sum exceeds 2^COUNT_WIDTH-1, countval SHALL saturate at 2^COUNT_WIDTH-1 and overflow SHALL set, sticky until the next frame's first beat.
REQ-015 After saturation, further beats SHALL keep countval saturated; the frame still terminates on bs_last.
REQ-016 countval SHALL not clear in IDLE; it retains the last result until the first beat of the next frame overwrites it.
REQ-017 busy=1 exactly in ACCUM.
REQ-018 out_valid SHALL not depend combinationally on out_ready; out_valid, countval and overflow are registered.
REQ-019 A single-beat frame (bs_last on the first beat) SHALL be legal and SHALL yield out_valid the next cycle.
REQ-020 en=0 SHALL not affect the output handshake: in HOLD, out_ready still releases the result.

Reset
REQ-021 On rst=1 at a clock edge: state<=IDLE, countval<=0, out_valid<=0, overflow<=0, busy<=0; bs_ready follows en on the next cycle.
REQ-022 rst mid-frame (ACCUM) or in HOLD SHALL discard the partial count or the pending result with no out_valid pulse.
REQ-023 rst SHALL take priority over every simultaneous beat or handshake event.

Verification
REQ-024 LANES=2, COUNT_WIDTH=10: beats 2'b11, 2'b01, 2'b10, 2'b11 (last) -> out_valid one cycle after the last beat, countval=6, overflow=0.
REQ-025 Single beat 2'b10 with bs_last, out_ready held 0 for 5 cycles -> out_valid=1 and countval=1 stable for all 5 cycles, bs_ready=0; out_ready=1 -> out_valid=0 next cycle, state IDLE.
REQ-026 COUNT_WIDTH=3, LANES=2: five beats 2'b11 (last on 5th) -> countval=7, overflow=1; next frame first beat 2'b01 -> overflow=0, countval=1.
REQ-027 Frame with bs_valid gaps and en=0 cycles interleaved (beats 11, 11, 01 last) -> countval=5; no beats counted while en=0 or bs_valid=0.
REQ-028 rst asserted after 3 beats of 2'b11 mid-frame -> countval=0, busy=0, no out_valid; next frame 2'b01 (last) -> countval=1.
REQ-029 HOLD with out_ready=1 and bs_valid=1 in the same cycle -> that beat is not accepted; it is accepted the following cycle as the first beat of a new frame.

Source files
------------

// File: rtl/bs_by2_acc_rx.sv
// Bitstream ones-counter: accumulates popcount of LANES-wide beats over a frame
// and holds the saturating result until downstream takes it.
module bs_by2_acc_rx #(
  parameter int unsigned LANES       = 2,
  parameter int unsigned COUNT_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   bs_valid,
  input  logic [LANES-1:0]       bs_data,
  input  logic                   bs_last,
  output logic                   bs_ready,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [COUNT_WIDTH-1:0] countval,
  output logic                   overflow,
  output logic                   busy
);

  localparam int unsigned SumW = COUNT_WIDTH + 1;
  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   ovf_q, ovf_d;

  logic [SumW-1:0] pop, base, sum;
  logic            sat, accept;

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + {{COUNT_WIDTH{1'b0}}, bs_data[i]};
    end
    // The first beat of a frame starts from zero rather than the retained result.
    base = (state_q == StIdle) ? '0 : {1'b0, count_q};
    sum  = base + pop;
    sat  = sum[COUNT_WIDTH];
  end

  assign bs_ready  = en & (state_q != StHold);
  assign accept    = bs_valid & bs_ready;
  assign out_valid = (state_q == StHold);
  assign busy      = (state_q == StAccum);
  assign countval  = count_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          count_d = sat ? CntMax : sum[COUNT_WIDTH-1:0];
          ovf_d   = sat;
          state_d = bs_last ? StHold : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          count_d = sat ? CntMax : sum[COUNT_WIDTH-1:0];
          ovf_d   = ovf_q | sat;
          if (bs_last) state_d = StHold;
        end
      end
      StHold: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_bs_by2_acc_rx.sv
// Directed bench for bs_by2_acc_rx; a second instance with COUNT_WIDTH=3 shares
// the stimulus to exercise saturation.
module tb_bs_by2_acc_rx;

  logic       clk;
  logic       rst, en, bs_valid, bs_last, out_ready;
  logic [1:0] bs_data;

  logic       bs_ready, out_valid, overflow, busy;
  logic [9:0] countval;
  logic       bs_ready3, out_valid3, overflow3, busy3;
  logic [2:0] countval3;

  int errors = 0;
  int checks = 0;

  bs_by2_acc_rx #(.LANES(2), .COUNT_WIDTH(10)) dut (
    .clk(clk), .rst(rst), .en(en), .bs_valid(bs_valid), .bs_data(bs_data),
    .bs_last(bs_last), .bs_ready(bs_ready), .out_ready(out_ready),
    .out_valid(out_valid), .countval(countval), .overflow(overflow), .busy(busy)
  );

  bs_by2_acc_rx #(.LANES(2), .COUNT_WIDTH(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .bs_valid(bs_valid), .bs_data(bs_data),
    .bs_last(bs_last), .bs_ready(bs_ready3), .out_ready(out_ready),
    .out_valid(out_valid3), .countval(countval3), .overflow(overflow3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [1:0] d, input logic l);
    bs_valid = 1'b1;
    bs_data  = d;
    bs_last  = l;
    tick();
    bs_valid = 1'b0;
    bs_last  = 1'b0;
    bs_data  = 2'b00;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; bs_valid = 1'b0; bs_last = 1'b0;
    bs_data = 2'b00; out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_countval", countval, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    check("rst_ready_en0", bs_ready, 0);
    rst = 1'b0;
    en  = 1'b1;
    #1;
    check("ready_follows_en", bs_ready, 1);

    // Basic 4-beat frame: 2+1+1+2 = 6
    beat(2'b11, 1'b0);
    check("f1_busy", busy, 1);
    check("f1_partial", countval, 2);
    check("f1_no_valid_mid", out_valid, 0);
    beat(2'b01, 1'b0);
    beat(2'b10, 1'b0);
    beat(2'b11, 1'b1);
    check("f1_valid", out_valid, 1);
    check("f1_count", countval, 6);
    check("f1_ovf", overflow, 0);
    check("f1_busy_hold", busy, 0);
    check("f1_ready_hold", bs_ready, 0);
    release_result();
    check("f1_valid_drop", out_valid, 0);
    check("f1_count_retained", countval, 6);

    // Single-beat frame held for 5 cycles
    beat(2'b10, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("f2_valid_held", out_valid, 1);
      check("f2_count_held", countval, 1);
      check("f2_ready_held", bs_ready, 0);
      tick();
    end
    release_result();
    check("f2_valid_drop", out_valid, 0);
    check("f2_idle_busy", busy, 0);
    check("f2_idle_ready", bs_ready, 1);

    // Saturation on the 3-bit instance: 2,4,6,7(sat),7
    beat(2'b11, 1'b0);
    beat(2'b11, 1'b0);
    beat(2'b11, 1'b0);
    check("f3_pre_sat", countval3, 6);
    check("f3_pre_ovf", overflow3, 0);
    beat(2'b11, 1'b0);
    check("f3_sat", countval3, 7);
    check("f3_ovf_set", overflow3, 1);
    beat(2'b11, 1'b1);
    check("f3_sat_final", countval3, 7);
    check("f3_ovf_final", overflow3, 1);
    check("f3_valid3", out_valid3, 1);
    check("f3_wide_count", countval, 10);
    check("f3_wide_ovf", overflow, 0);
    release_result();
    check("f3_ovf_sticky_idle", overflow3, 1);
    beat(2'b01, 1'b0);
    check("f4_ovf_clear", overflow3, 0);
    check("f4_count", countval3, 1);
    beat(2'b00, 1'b1);
    check("f4_final", countval3, 1);
    release_result();

    // Gaps: en=0 and bs_valid=0 interleaved; 2+2+1 = 5
    beat(2'b11, 1'b0);
    en = 1'b0; bs_valid = 1'b1; bs_data = 2'b11;
    #1;
    check("f5_ready_en0", bs_ready, 0);
    tick();
    check("f5_en0_count", countval, 2);
    check("f5_en0_busy", busy, 1);
    en = 1'b1; bs_valid = 1'b0;
    tick();
    check("f5_gap_count", countval, 2);
    beat(2'b11, 1'b0);
    check("f5_count4", countval, 4);
    en = 1'b0; bs_valid = 1'b1; bs_data = 2'b01; bs_last = 1'b1;
    tick();
    check("f5_en0_last_ignored", out_valid, 0);
    check("f5_en0_last_count", countval, 4);
    en = 1'b1;
    beat(2'b01, 1'b1);
    check("f5_valid", out_valid, 1);
    check("f5_count", countval, 5);
    en = 1'b0;
    release_result();
    check("f5_release_en0", out_valid, 0);
    en = 1'b1;

    // Reset mid-frame with a simultaneous beat
    beat(2'b11, 1'b0);
    beat(2'b11, 1'b0);
    beat(2'b11, 1'b0);
    check("f6_pre_rst", countval, 6);
    rst = 1'b1; bs_valid = 1'b1; bs_data = 2'b11; bs_last = 1'b1;
    tick();
    rst = 1'b0; bs_valid = 1'b0; bs_last = 1'b0;
    check("f6_rst_count", countval, 0);
    check("f6_rst_busy", busy, 0);
    check("f6_rst_valid", out_valid, 0);
    tick();
    check("f6_no_pulse", out_valid, 0);
    beat(2'b01, 1'b1);
    check("f6_next_count", countval, 1);
    check("f6_next_valid", out_valid, 1);
    rst = 1'b1; out_ready = 1'b0;
    tick();
    rst = 1'b0;
    check("f6_rst_hold_valid", out_valid, 0);
    check("f6_rst_hold_count", countval, 0);

    // Beat offered in HOLD while releasing: taken only in the next IDLE cycle
    beat(2'b11, 1'b1);
    check("f7_hold_count", countval, 2);
    out_ready = 1'b1; bs_valid = 1'b1; bs_data = 2'b01;
    #1;
    check("f7_hold_ready", bs_ready, 0);
    tick();
    out_ready = 1'b0;
    check("f7_not_accepted", countval, 2);
    check("f7_valid_drop", out_valid, 0);
    check("f7_idle_ready", bs_ready, 1);
    tick();
    bs_valid = 1'b0;
    check("f7_new_frame", countval, 1);
    check("f7_busy", busy, 1);
    beat(2'b10, 1'b1);
    check("f7_final", countval, 2);
    release_result();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
